shift_seq_reg: RTL and testbench
================================

# shift_seq_reg

Parametrised sequenced shift register for the storage-element lab series. It holds a WIDTH-bit word that can be parallel-loaded, then shifted left or right by a requested number of positions, one position per clock. A start/busy/done handshake lets a controller or FSM request a multi-step shift and wait for it to finish. It sits alongside the single-bit latch and flip-flop primitives as the multi-bit, counted successor built from the same positive-edge storage.

## Interface

Parameters:
- WIDTH, 8: data width in bits, ≥ 2.
- CNT_W, 4: width of the shift-amount field; maximum request is 2^CNT_W − 1.

Ports:
- clock  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- load  in  1  parallel load request; honoured only while idle.
- D  in  WIDTH  parallel load data.
- start  in  1  shift request; honoured only while idle.
- dir  in  1  0 = shift right (toward bit 0), 1 = shift left.
- amount  in  CNT_W  number of single-bit shifts.
- serial_in  in  1  fill bit for the vacated position.
- rotate  in  1  rotate select; effective only with ROTATE_MODE_EN.
- Q  out  WIDTH  stored word.
- Qb  out  WIDTH  ~Q, combinational.
- serial_out  out  1  last bit shifted out.
- busy  out  1  shift sequence in progress.
- done  out  1  one-cycle completion pulse.

## Operation

- Reset: Q = 0, Qb = all ones, serial_out = 0, busy = 0, done = 0, counter = 0, state IDLE.
- States: IDLE and SHIFT. Moore outputs: busy = (state == SHIFT). done is a registered pulse.
- IDLE, load = 1: Q <= D. load takes priority, so start in the same cycle is dropped.
- IDLE, start = 1, load = 0: latch dir and rotate, and set counter <= amount.
  - If amount ≠ 0, go to SHIFT.
  - If amount = 0, stay in IDLE, set done <= 1, and leave Q unchanged.
- SHIFT, each edge: perform one shift and decrement the counter.
  - When the counter is 1 at the edge, this is the last shift: go to IDLE and set done <= 1.
- Right shift: Q <= {fill, Q[WIDTH-1:1]}, and serial_out <= Q[0].
- Left shift: Q <= {Q[WIDTH-2:0], fill}, and serial_out <= Q[WIDTH-1].
- fill = serial_in sampled at that edge, or the outgoing bit when rotating.
- During SHIFT, load, start, dir, amount and rotate changes are ignored. The latched copies are used.
- serial_out holds its value on non-shift cycles.
- amount ≥ WIDTH without rotate fully replaces Q with serial_in history; there is no saturation or error.
- Counter width is CNT_W; no wrap is possible because it only decrements to 0.

## Timing

- Request edge E0 samples start.
- Shifts occur at edges E1 … Ek, where k = amount.
- busy is high for exactly k cycles, from after E0 to after Ek.
- done is high for the single cycle after Ek. busy falls in the same cycle done rises.
- amount = 0: done is high for the cycle after E0, and busy never asserts.
- Load latency: 1 edge.
- Back-to-back: start may be asserted during the done cycle, since the block is idle, and is accepted at that edge.
- reset mid-sequence: at the next edge with reset = 1, all outputs return to reset values. No done pulse is produced, and the partial shift is discarded.
- reset has priority over load and start.

## Configuration

- ROTATE_MODE_EN defined: when rotate = 1 is latched at start, fill is the bit shifted out in the same step, giving a circular shift. serial_out still reports that bit.
- ROTATE_MODE_EN undefined: the rotate port is present but ignored, and fill is always serial_in.

## Test plan

- Reset: hold reset 2 cycles mid-activity -> Q = 0x00, Qb = 0xFF, busy = 0, done = 0, serial_out = 0.
- Load priority: load = 1, D = 0xA5, start = 1, amount = 3 in the same cycle -> Q = 0xA5 after 1 edge; busy stays 0; no done.
- Right shift: Q = 0xA5, dir = 0, amount = 3, serial_in = 1 -> Q steps 0xD2, 0xE9, 0xF4. busy high exactly 3 cycles, then a 1-cycle done. serial_out = 1 at the end.
- Zero amount / back-to-back: start with amount = 0 -> done the next cycle, Q unchanged, busy never 1. A second start (amount = 1, dir = 1, serial_in = 0) in the done cycle is accepted -> Q = 0xE8.
- Rotate (ROTATE_MODE_EN): Q = 0x81, dir = 1, rotate = 1, amount = 1 -> Q = 0x03. Then amount = 8 -> Q = 0x03 restored after 8 busy cycles. With the macro undefined and serial_in = 0, the first request gives Q = 0x02.
- Mid-operation reset and ignored inputs: start amount = 5; change dir and amount, and pulse load, while busy; assert reset after 2 shifts -> the changes have no effect, Q = 0, busy = 0, and no done pulse ever asserts.

Source files
------------

// File: rtl/shift_seq_reg.sv
// rtl/shift_seq_reg.sv - sequenced shift register: parallel load, counted left/right shift, start/busy/done handshake
// Optional feature macro: ROTATE_MODE_EN (circular shift when rotate is latched at start)
module shift_seq_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] D,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] amount,
    input  logic             serial_in,
    input  logic             rotate,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qb,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir;
    logic             r_sout;
    logic             r_busy;
    logic             r_done;

    logic             w_out_bit;
    logic             w_fill;
    logic [WIDTH-1:0] w_shifted;

    assign w_out_bit = r_dir ? r_q[WIDTH-1] : r_q[0];

`ifdef ROTATE_MODE_EN
    logic r_rot;
    // Rotating recycles the bit leaving the word as the new fill bit.
    assign w_fill = r_rot ? w_out_bit : serial_in;
`else
    logic w_unused_rotate;
    assign w_unused_rotate = rotate;
    assign w_fill          = serial_in;
`endif

    assign w_shifted = r_dir ? {r_q[WIDTH-2:0], w_fill}
                             : {w_fill, r_q[WIDTH-1:1]};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_q     <= '0;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_sout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef ROTATE_MODE_EN
            r_rot   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        r_q <= D;
                    end else if (start) begin
                        r_dir <= dir;
                        r_cnt <= amount;
`ifdef ROTATE_MODE_EN
                        r_rot <= rotate;
`endif
                        if (amount != '0) begin
                            r_state <= ST_SHIFT;
                            r_busy  <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_q    <= w_shifted;
                    r_sout <= w_out_bit;
                    r_cnt  <= r_cnt - 1'b1;
                    // Counter at 1 means this edge performs the final shift.
                    if (r_cnt == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Q          = r_q;
    assign Qb         = ~r_q;
    assign serial_out = r_sout;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_shift_seq_reg.sv
// tb/tb_shift_seq_reg.sv - directed self-checking bench for shift_seq_reg
module tb_shift_seq_reg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] D;
    logic             start;
    logic             dir;
    logic [CNT_W-1:0] amount;
    logic             serial_in;
    logic             rotate;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Qb;
    logic             serial_out;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;

    shift_seq_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .D          (D),
        .start      (start),
        .dir        (dir),
        .amount     (amount),
        .serial_in  (serial_in),
        .rotate     (rotate),
        .Q          (Q),
        .Qb         (Qb),
        .serial_out (serial_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int n;
        reset = 1'b1; load = 1'b1; D = 8'h5A; start = 1'b1; dir = 1'b0;
        amount = 4'd3; serial_in = 1'b1; rotate = 1'b0;

        tick(); tick();
        check("rst_q", Q, 8'h00);
        check("rst_qb", Qb, 8'hFF);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sout", serial_out, 0);

        reset = 1'b0; load = 1'b1; D = 8'hA5; start = 1'b1; amount = 4'd3;
        tick();
        load = 1'b0; start = 1'b0;
        check("load_q", Q, 8'hA5);
        check("load_busy", busy, 0);
        check("load_done", done, 0);
        tick();
        check("load_busy2", busy, 0);
        check("load_done2", done, 0);

        dir = 1'b0; amount = 4'd3; serial_in = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("rs_e0_busy", busy, 1);
        check("rs_e0_q", Q, 8'hA5);
        tick();
        check("rs_e1_q", Q, 8'hD2);
        check("rs_e1_sout", serial_out, 1);
        check("rs_e1_busy", busy, 1);
        tick();
        check("rs_e2_q", Q, 8'hE9);
        check("rs_e2_sout", serial_out, 0);
        check("rs_e2_done", done, 0);
        tick();
        check("rs_e3_q", Q, 8'hF4);
        check("rs_e3_sout", serial_out, 1);
        check("rs_e3_busy", busy, 0);
        check("rs_e3_done", done, 1);

        start = 1'b1; amount = 4'd0;
        tick();
        check("z_done", done, 1);
        check("z_busy", busy, 0);
        check("z_q", Q, 8'hF4);

        amount = 4'd1; dir = 1'b1; serial_in = 1'b0;
        tick();
        start = 1'b0;
        check("b2b_busy", busy, 1);
        check("b2b_done", done, 0);
        tick();
        check("b2b_q", Q, 8'hE8);
        check("b2b_sout", serial_out, 1);
        check("b2b_done2", done, 1);
        check("b2b_qb", Qb, 8'h17);
        tick();
        check("b2b_done_off", done, 0);

        load = 1'b1; D = 8'h81;
        tick();
        load = 1'b0;
        dir = 1'b1; rotate = 1'b1; amount = 4'd1; serial_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
`ifdef ROTATE_MODE_EN
        check("rot1_q", Q, 8'h03);
`else
        check("rot1_q", Q, 8'h02);
`endif
        check("rot1_sout", serial_out, 1);
        check("rot1_done", done, 1);

        amount = 4'd8; start = 1'b1;
        tick();
        start = 1'b0; rotate = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            n++;
            tick();
        end
        check("rot8_busy_cycles", n, 8);
        check("rot8_done", done, 1);
`ifdef ROTATE_MODE_EN
        check("rot8_q", Q, 8'h03);
`else
        check("rot8_q", Q, 8'h00);
`endif
        tick();

        load = 1'b1; D = 8'h3C;
        tick();
        load = 1'b0;
        check("mid_load_q", Q, 8'h3C);
        dir = 1'b0; amount = 4'd5; serial_in = 1'b0; rotate = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        dir = 1'b1; amount = 4'd2; load = 1'b1; D = 8'hFF;
        tick();
        check("mid_e1_q", Q, 8'h1E);
        check("mid_e1_done", done, 0);
        load = 1'b0;
        tick();
        check("mid_e2_q", Q, 8'h0F);
        check("mid_e2_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_q", Q, 8'h00);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_post_done", done, 0);
        end
        check("mid_post_q", Q, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
